// File: rtl/memoria_pkg.sv
// Shared constants and types for the register-bank memory responder.
package memoria_pkg;

  localparam int unsigned MEM_ADDR_WIDTH = 4;
  localparam int unsigned MEM_DATA_WIDTH = 32;
  localparam int unsigned CNT_WIDTH      = 4;

  // Command encodings on pc_data
  typedef logic [1:0] cmd_t;
  localparam cmd_t CMD_IDLE  = 2'b00;
  localparam cmd_t CMD_READ  = 2'b01;
  localparam cmd_t CMD_WRITE = 2'b10;
  localparam cmd_t CMD_RSVD  = 2'b11;

  // Controller FSM states
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_ACCESS = 2'd1;
  localparam state_t ST_DONE   = 2'd2;

endpackage

// File: rtl/memoria_array.sv
// Word-addressed register array: synchronous write, registered read on strobe,
// asynchronous clear of every word and of the read register.
module memoria_array
  import memoria_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = MEM_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = MEM_DATA_WIDTH
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_we,
  input  logic                  i_re,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rdata;

  // Storage: cleared by reset, written on strobe
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

  // Read register: only updated by a read strobe
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/controlador_ram.sv
// Memory-side responder: accepts a command from the register bank, waits a
// programmable latency, executes it once and holds ready until the command drops.
module controlador_ram
  import memoria_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = MEM_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = MEM_DATA_WIDTH,
  parameter int unsigned LATENCY    = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] mar_data,
  input  logic [1:0]            pc_data,
  input  logic [DATA_WIDTH-1:0] mbr_data,
  output logic [DATA_WIDTH-1:0] ram_data,
  output logic                  busy,
  output logic                  ready,
  output logic                  err
);

  localparam logic [CNT_WIDTH-1:0] CNT_LOAD = CNT_WIDTH'(LATENCY - 1);

  state_t                r_state;
  logic [CNT_WIDTH-1:0]  r_cnt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  cmd_t                  r_cmd;
  logic                  r_err;
  logic                  r_busy;
  logic                  r_ready;

  state_t                w_state_nxt;
  logic [CNT_WIDTH-1:0]  w_cnt_nxt;
  logic [ADDR_WIDTH-1:0] w_addr_nxt;
  logic [DATA_WIDTH-1:0] w_wdata_nxt;
  cmd_t                  w_cmd_nxt;
  logic                  w_err_nxt;
  logic                  w_busy_nxt;
  logic                  w_ready_nxt;
  logic                  w_we;
  logic                  w_re;
  logic [DATA_WIDTH-1:0] w_rdata;

  // State, capture and flag registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_cmd   <= CMD_IDLE;
      r_err   <= 1'b0;
      r_busy  <= 1'b0;
      r_ready <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_addr  <= w_addr_nxt;
      r_wdata <= w_wdata_nxt;
      r_cmd   <= w_cmd_nxt;
      r_err   <= w_err_nxt;
      r_busy  <= w_busy_nxt;
      r_ready <= w_ready_nxt;
    end
  end

  // Next-state logic; execution strobes fire on the last ACCESS edge
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_addr_nxt  = r_addr;
    w_wdata_nxt = r_wdata;
    w_cmd_nxt   = r_cmd;
    w_err_nxt   = r_err;
    w_we        = 1'b0;
    w_re        = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (pc_data != CMD_IDLE) begin
          w_addr_nxt  = mar_data;
          w_wdata_nxt = mbr_data;
          w_cmd_nxt   = pc_data;
          w_cnt_nxt   = CNT_LOAD;
          if (pc_data == CMD_RSVD) begin
            // Reserved command completes immediately with no memory effect
            w_err_nxt   = 1'b1;
            w_state_nxt = ST_DONE;
          end else begin
            w_err_nxt   = 1'b0;
            w_state_nxt = ST_ACCESS;
          end
        end
      end
      ST_ACCESS: begin
        if (r_cnt == '0) begin
          w_we        = (r_cmd == CMD_WRITE);
          w_re        = (r_cmd == CMD_READ);
          w_state_nxt = ST_DONE;
        end else begin
          w_cnt_nxt = r_cnt - CNT_WIDTH'(1);
        end
      end
      ST_DONE: begin
        // Level handshake: leave only once the command is withdrawn
        if (pc_data == CMD_IDLE) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    w_busy_nxt  = (w_state_nxt == ST_ACCESS);
    w_ready_nxt = (w_state_nxt == ST_DONE);
  end

  memoria_array #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_array (
    .i_clk   (clock),
    .i_rst   (reset),
    .i_we    (w_we),
    .i_re    (w_re),
    .i_addr  (r_addr),
    .i_wdata (r_wdata),
    .o_rdata (w_rdata)
  );

  assign ram_data = w_rdata;
  assign busy     = r_busy;
  assign ready    = r_ready;
  assign err      = r_err;

endmodule

// File: tb/tb_controlador_ram.sv
// Directed bench for controlador_ram: LATENCY=2 instance plus a LATENCY=1 instance.
module tb_controlador_ram;

  logic        clock;
  logic        reset;

  logic [3:0]  mar;
  logic [1:0]  pc;
  logic [31:0] mbr;
  logic [31:0] ram;
  logic        busy, ready, err;

  logic [3:0]  mar1;
  logic [1:0]  pc1;
  logic [31:0] mbr1;
  logic [31:0] ram1;
  logic        busy1, ready1, err1;

  int total;
  int bad;

  controlador_ram #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .LATENCY(2)) dut (
    .clock(clock), .reset(reset), .mar_data(mar), .pc_data(pc), .mbr_data(mbr),
    .ram_data(ram), .busy(busy), .ready(ready), .err(err)
  );

  controlador_ram #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .LATENCY(1)) dut1 (
    .clock(clock), .reset(reset), .mar_data(mar1), .pc_data(pc1), .mbr_data(mbr1),
    .ram_data(ram1), .busy(busy1), .ready(ready1), .err(err1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one rising edge and settle just after it
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Reset values, then a command held through reset release is accepted at once
  task automatic test_reset();
    reset = 1'b1;
    pc = 2'b01; mar = 4'd7; mbr = 32'h0;
    pc1 = 2'b00; mar1 = 4'd0; mbr1 = 32'h0;
    tick(); tick();
    total++; if ({busy, ready, err} !== 3'b000) begin bad++; $display("FAIL rst_flags got=%b want=%b", {busy, ready, err}, 3'b000); end
    total++; if (ram !== 32'h0) begin bad++; $display("FAIL rst_ram got=%h want=%h", ram, 32'h0); end
    total++; if ({busy1, ready1, err1, ram1} !== 35'h0) begin bad++; $display("FAIL rst_dut1 got=%h want=%h", {busy1, ready1, err1, ram1}, 35'h0); end
    reset = 1'b0;
    tick();
    total++; if ({busy, ready, err} !== 3'b100) begin bad++; $display("FAIL rd7_accept got=%b want=%b", {busy, ready, err}, 3'b100); end
    tick();
    total++; if ({busy, ready, err} !== 3'b100) begin bad++; $display("FAIL rd7_access2 got=%b want=%b", {busy, ready, err}, 3'b100); end
    tick();
    total++; if ({busy, ready, err} !== 3'b010) begin bad++; $display("FAIL rd7_done got=%b want=%b", {busy, ready, err}, 3'b010); end
    total++; if (ram !== 32'h0) begin bad++; $display("FAIL rd7_data got=%h want=%h", ram, 32'h0); end
    pc = 2'b00;
    tick();
    total++; if ({busy, ready, err} !== 3'b000) begin bad++; $display("FAIL rd7_idle got=%b want=%b", {busy, ready, err}, 3'b000); end
  endtask

  // Write then read back address 3; write leaves ram_data alone
  task automatic test_write_read();
    pc = 2'b10; mar = 4'd3; mbr = 32'hDEAD_BEEF;
    tick();
    total++; if ({busy, ready} !== 2'b10) begin bad++; $display("FAIL wr3_accept got=%b want=%b", {busy, ready}, 2'b10); end
    tick(); tick();
    total++; if ({busy, ready} !== 2'b01) begin bad++; $display("FAIL wr3_done got=%b want=%b", {busy, ready}, 2'b01); end
    total++; if (ram !== 32'h0) begin bad++; $display("FAIL wr3_ram_unchanged got=%h want=%h", ram, 32'h0); end
    pc = 2'b00; mbr = 32'h0;
    tick();
    pc = 2'b01; mar = 4'd3;
    tick(); tick();
    total++; if ({busy, ready} !== 2'b10) begin bad++; $display("FAIL rd3_still_busy got=%b want=%b", {busy, ready}, 2'b10); end
    tick();
    total++; if (ram !== 32'hDEAD_BEEF) begin bad++; $display("FAIL rd3_data got=%h want=%h", ram, 32'hDEAD_BEEF); end
    pc = 2'b00;
    tick();
  endtask

  // Held write with changing data executes once with the accepted value
  task automatic test_held_write();
    pc = 2'b10; mar = 4'd5; mbr = 32'hA000_0000;
    for (int i = 0; i < 20; i++) begin
      logic [1:0] exp_f;
      tick();
      exp_f = (i < 2) ? 2'b10 : 2'b01;
      total++; if ({busy, ready} !== exp_f) begin bad++; $display("FAIL held_cycle%0d got=%b want=%b", i, {busy, ready}, exp_f); end
      mbr = 32'hA000_0000 + 32'(i + 1);
      mar = 4'(i);
    end
    total++; if (ram !== 32'hDEAD_BEEF) begin bad++; $display("FAIL held_ram_unchanged got=%h want=%h", ram, 32'hDEAD_BEEF); end
    pc = 2'b00;
    tick();
    total++; if ({busy, ready} !== 2'b00) begin bad++; $display("FAIL held_release got=%b want=%b", {busy, ready}, 2'b00); end
    pc = 2'b01; mar = 4'd5;
    tick(); tick(); tick();
    total++; if (ram !== 32'hA000_0000) begin bad++; $display("FAIL held_readback got=%h want=%h", ram, 32'hA000_0000); end
    pc = 2'b00;
    tick();
  endtask

  // Reserved command: immediate ready+err, no busy, no memory effect
  task automatic test_reserved();
    pc = 2'b11; mar = 4'd3; mbr = 32'h1111_1111;
    tick();
    total++; if ({busy, ready, err} !== 3'b011) begin bad++; $display("FAIL rsvd_accept got=%b want=%b", {busy, ready, err}, 3'b011); end
    total++; if (ram !== 32'hA000_0000) begin bad++; $display("FAIL rsvd_ram got=%h want=%h", ram, 32'hA000_0000); end
    tick();
    total++; if ({busy, ready, err} !== 3'b011) begin bad++; $display("FAIL rsvd_hold got=%b want=%b", {busy, ready, err}, 3'b011); end
    pc = 2'b00;
    tick();
    total++; if ({busy, ready, err} !== 3'b001) begin bad++; $display("FAIL rsvd_idle got=%b want=%b", {busy, ready, err}, 3'b001); end
    pc = 2'b01; mar = 4'd3;
    tick();
    total++; if ({busy, ready, err} !== 3'b100) begin bad++; $display("FAIL rsvd_err_clear got=%b want=%b", {busy, ready, err}, 3'b100); end
    tick(); tick();
    total++; if (ram !== 32'hDEAD_BEEF) begin bad++; $display("FAIL rsvd_mem_intact got=%h want=%h", ram, 32'hDEAD_BEEF); end
    pc = 2'b00;
    tick();
  endtask

  // Reset mid-ACCESS aborts the write and clears memory
  task automatic test_reset_abort();
    pc = 2'b10; mar = 4'd15; mbr = 32'h1234_5678;
    tick();
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL abort_busy got=%b want=%b", busy, 1'b1); end
    #2 reset = 1'b1;
    #1;
    total++; if ({busy, ready, err, ram} !== 35'h0) begin bad++; $display("FAIL abort_immediate got=%h want=%h", {busy, ready, err, ram}, 35'h0); end
    pc = 2'b00; mbr = 32'h0;
    tick();
    reset = 1'b0;
    pc = 2'b01; mar = 4'd15;
    tick(); tick(); tick();
    total++; if ({busy, ready} !== 2'b01) begin bad++; $display("FAIL abort_rd_done got=%b want=%b", {busy, ready}, 2'b01); end
    total++; if (ram !== 32'h0) begin bad++; $display("FAIL abort_rd15 got=%h want=%h", ram, 32'h0); end
    pc = 2'b00;
    tick();
  endtask

  // LATENCY=1: write then read at minimum spacing; single-cycle ready when cmd already 00
  task automatic test_back_to_back();
    pc1 = 2'b10; mar1 = 4'd0; mbr1 = 32'hCAFE_F00D;
    tick();
    total++; if ({busy1, ready1} !== 2'b10) begin bad++; $display("FAIL l1_wr_accept got=%b want=%b", {busy1, ready1}, 2'b10); end
    tick();
    total++; if ({busy1, ready1} !== 2'b01) begin bad++; $display("FAIL l1_wr_done got=%b want=%b", {busy1, ready1}, 2'b01); end
    total++; if (ram1 !== 32'h0) begin bad++; $display("FAIL l1_wr_ram got=%h want=%h", ram1, 32'h0); end
    pc1 = 2'b00; mbr1 = 32'h0;
    tick();
    total++; if ({busy1, ready1} !== 2'b00) begin bad++; $display("FAIL l1_idle got=%b want=%b", {busy1, ready1}, 2'b00); end
    pc1 = 2'b01;
    tick();
    total++; if ({busy1, ready1} !== 2'b10) begin bad++; $display("FAIL l1_rd_accept got=%b want=%b", {busy1, ready1}, 2'b10); end
    pc1 = 2'b00;
    tick();
    total++; if ({busy1, ready1} !== 2'b01) begin bad++; $display("FAIL l1_rd_done got=%b want=%b", {busy1, ready1}, 2'b01); end
    total++; if (ram1 !== 32'hCAFE_F00D) begin bad++; $display("FAIL l1_rd_data got=%h want=%h", ram1, 32'hCAFE_F00D); end
    tick();
    total++; if ({busy1, ready1} !== 2'b00) begin bad++; $display("FAIL l1_ready_one_cycle got=%b want=%b", {busy1, ready1}, 2'b00); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_write_read();
    test_held_write();
    test_reserved();
    test_reset_abort();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
